// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, command/response codes,
// and a sizing helper for the timeout counter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK,
    WAIT_REL,
    DONE,
    ERROR
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  // Largest of three cycle counts; one counter serves every timed phase.
  function automatic int ps2_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the raw PS/2 clock and data pins plus a
// one-cycle pulse on each synchronised clock falling edge.
module ps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta, data_meta, clk_prev;

  // Idle bus is pulled high, so every flop resets to 1 to avoid a false edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= data_in;
      data_sync <= data_meta;
    end
  end

  assign clk_fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits LSB
// first, odd parity, stop, then checks the device ACK. Open-drain lines are
// modelled as active-high "pull low" enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10_000,
  parameter int START_TIMEOUT  = 1_500_000,
  parameter int XFER_TIMEOUT   = 200_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = ps2_max3(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TIMEOUT - 1);

  ps2_tx_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_idx, bit_idx_n;
  logic [8:0]    shift, shift_n;
  logic          clk_sync, data_sync, clk_fall;

  ps2_line_sync u_sync (
    .clock     (clock),
    .reset     (reset),
    .clk_in    (ps2_clk_in),
    .data_in   (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  // State, shared timeout counter, bit index and frame shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  // Next-state logic; the counter restarts on every timed phase entry and at
  // the first device falling edge so the transfer timeout spans the frame.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (tx_valid) begin
          state_n = INHIBIT;
          shift_n = {~^tx_data, tx_data};
        end
      end
      INHIBIT: if (cnt == INH_LAST) begin
        state_n = REQ;
        cnt_n   = '0;
      end
      REQ: begin
        if (clk_fall) begin
          state_n   = BITS;
          bit_idx_n = '0;
          cnt_n     = '0;
        end else if (cnt == START_LAST) begin
          state_n = ERROR;
        end
      end
      BITS: begin
        if (cnt == XFER_LAST)      state_n = ERROR;
        else if (clk_fall) begin
          if (bit_idx == 4'd8)     state_n = ACK;
          else                     bit_idx_n = bit_idx + 4'd1;
        end
      end
      ACK: begin
        if (cnt == XFER_LAST)      state_n = ERROR;
        else if (clk_fall)         state_n = data_sync ? ERROR : WAIT_REL;
      end
      WAIT_REL: begin
        if (cnt == XFER_LAST)          state_n = ERROR;
        else if (clk_sync && data_sync) state_n = DONE;
      end
      DONE, ERROR: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Line drives decode straight from registered state, so reset releases
  // both lines immediately and data moves only after a registered fall.
  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state)
      INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = (cnt == INH_LAST);
      end
      REQ:     ps2_data_oe = 1'b1;
      BITS:    ps2_data_oe = ~shift[bit_idx];
      default: ;
    endcase
  end

  assign tx_ready   = (state == IDLE);
  assign rx_inhibit = (state != IDLE);
  assign tx_done    = (state == DONE);
  assign tx_error   = (state == ERROR);

endmodule
